// File: rtl/dtc_result_collector.sv
// dtc_result_collector: accuracy statistics for the decision-tree classifier.
// Consumes (predicted, expected) class pairs through a one-deep input stage and
// keeps per-class label/hit/prediction counters plus global totals. All counters
// saturate. A clear request wipes the totals at once and sweeps the per-class
// banks one entry per cycle. A registered read port gives access to every bank
// entry.
module dtc_result_collector #(
  parameter int CLS_W   = 3,
  parameter int NUM_CLS = 8,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [CLS_W-1:0] in_pred,
  input  logic [CLS_W-1:0] in_label,
  input  logic             clear,
  input  logic             rd_en,
  input  logic [1:0]       rd_sel,
  input  logic [CLS_W-1:0] rd_addr,
  output logic             rd_valid,
  output logic [CNT_W-1:0] rd_data,
  output logic [CNT_W-1:0] total_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic             saturated,
  output logic             busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  // Saturating increment: a counter at its maximum keeps its value.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX) ? v : v + CNT_W'(1);
  endfunction

  // True when incrementing this counter would overflow it.
  function automatic logic at_max(input logic [CNT_W-1:0] v);
    return (v == CNT_MAX);
  endfunction

  state_t           r_state;
  logic [CLS_W-1:0] r_sweep;
  logic             r_live;

  logic             r_s1_vld;
  logic [CLS_W-1:0] r_s1_pred;
  logic [CLS_W-1:0] r_s1_label;

  logic [CNT_W-1:0] r_label_cnt [NUM_CLS];
  logic [CNT_W-1:0] r_hit_cnt   [NUM_CLS];
  logic [CNT_W-1:0] r_pred_cnt  [NUM_CLS];

  logic [CNT_W-1:0] r_total;
  logic [CNT_W-1:0] r_err;
  logic             r_sat;

  logic             r_rd_vld;
  logic [CNT_W-1:0] r_rd_data;

  logic             w_clr_go;
  logic             w_accept;
  logic             w_commit;
  logic             w_hit;
  logic             w_sat_evt;

  // A clear is only acted on from RUN; during the sweep it is ignored.
  assign w_clr_go = clear && (r_state == ST_RUN);
  // clear blocks the handshake combinationally so it always wins over in_valid.
  assign in_ready = r_live && (r_state == ST_RUN) && !clear;
  assign w_accept = in_valid && in_ready;
  // A sample sitting in stage 1 when clear is taken is dropped, not committed.
  assign w_commit = r_s1_vld && (r_state == ST_RUN) && !w_clr_go;
  assign w_hit    = (r_s1_pred == r_s1_label);

  assign w_sat_evt = w_commit &&
                     (at_max(r_label_cnt[r_s1_label]) ||
                      at_max(r_pred_cnt[r_s1_pred])   ||
                      at_max(r_total)                 ||
                      (w_hit  && at_max(r_hit_cnt[r_s1_label])) ||
                      (!w_hit && at_max(r_err)));

  assign busy      = (r_state == ST_CLEAR);
  assign total_cnt = r_total;
  assign err_cnt   = r_err;
  assign saturated = r_sat;
  assign rd_valid  = r_rd_vld;
  assign rd_data   = r_rd_data;

  // Run/clear state machine; the sweep index walks every bank entry once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_RUN;
      r_sweep <= '0;
      r_live  <= 1'b0;
    end else begin
      r_live <= 1'b1;
      case (r_state)
        ST_RUN: begin
          if (clear) begin
            r_state <= ST_CLEAR;
            r_sweep <= '0;
          end
        end
        ST_CLEAR: begin
          if (r_sweep == CLS_W'(NUM_CLS - 1)) begin
            r_state <= ST_RUN;
          end
          r_sweep <= r_sweep + CLS_W'(1);
        end
        default: r_state <= ST_RUN;
      endcase
    end
  end

  // Stage 1 valid: loaded on each handshake, flushed when clear is taken.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_vld <= 1'b0;
    end else if (w_clr_go) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= w_accept;
    end
  end

  // Stage 1 payload: only meaningful while r_s1_vld is set, so no reset.
  always_ff @(posedge clk) begin
    if (w_accept) begin
      r_s1_pred  <= in_pred;
      r_s1_label <= in_label;
    end
  end

  // Per-class banks: sweep-wipe during CLEAR, otherwise count committed pairs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < NUM_CLS; k++) begin
        r_label_cnt[k] <= '0;
        r_hit_cnt[k]   <= '0;
        r_pred_cnt[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CLS; k++) begin
        if ((r_state == ST_CLEAR) && (r_sweep == CLS_W'(k))) begin
          r_label_cnt[k] <= '0;
          r_hit_cnt[k]   <= '0;
          r_pred_cnt[k]  <= '0;
        end else if (w_commit) begin
          if (r_s1_label == CLS_W'(k)) begin
            r_label_cnt[k] <= sat_inc(r_label_cnt[k]);
            if (w_hit) begin
              r_hit_cnt[k] <= sat_inc(r_hit_cnt[k]);
            end
          end
          if (r_s1_pred == CLS_W'(k)) begin
            r_pred_cnt[k] <= sat_inc(r_pred_cnt[k]);
          end
        end
      end
    end
  end

  // Global totals and the sticky saturation flag; cleared at once on clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_total <= '0;
      r_err   <= '0;
      r_sat   <= 1'b0;
    end else if (w_clr_go) begin
      r_total <= '0;
      r_err   <= '0;
      r_sat   <= 1'b0;
    end else if (w_commit) begin
      r_total <= sat_inc(r_total);
      if (!w_hit) begin
        r_err <= sat_inc(r_err);
      end
      if (w_sat_evt) begin
        r_sat <= 1'b1;
      end
    end
  end

  // Registered read port; samples bank contents before this edge's commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_vld  <= 1'b0;
      r_rd_data <= '0;
    end else begin
      r_rd_vld <= rd_en;
      if (rd_en) begin
        case (rd_sel)
          2'd0:    r_rd_data <= r_label_cnt[rd_addr];
          2'd1:    r_rd_data <= r_hit_cnt[rd_addr];
          2'd2:    r_rd_data <= r_pred_cnt[rd_addr];
          default: r_rd_data <= '0;
        endcase
      end
    end
  end

endmodule
